// File: rtl/ss_pkg.sv
// Shared types and widths for the mapper save-state sequencer.
package ss_pkg;

  localparam int SS_AW        = 8;
  localparam int SS_DW        = 8;
  localparam int CNT_W        = 8;
  localparam int RO_ADDR_DFLT = 127;

  typedef enum logic [3:0] {
    IDLE,
    SV_SETUP,
    SV_CAP,
    LD_RD,
    LD_SETUP,
    LD_STB,
    LD_HOLD,
    NEXT,
    FIN
  } state_t;

  typedef enum logic {
    OP_SAVE,
    OP_LOAD
  } op_t;

endpackage

// File: rtl/ss_sequencer_if.sv
// Mapper save-state port plus snapshot buffer RAM port, as seen by the sequencer.
interface ss_sequencer_if;
  import ss_pkg::*;

  logic             ss_act;
  logic             ss_we;
  logic [SS_AW-1:0] ss_addr;
  logic [SS_DW-1:0] ss_wdat;
  logic [SS_DW-1:0] ss_rdat;
  logic [SS_AW-1:0] mem_addr;
  logic             mem_we;
  logic [SS_DW-1:0] mem_wdat;
  logic [SS_DW-1:0] mem_rdat;

  modport master (
    output ss_act, ss_we, ss_addr, ss_wdat, mem_addr, mem_we, mem_wdat,
    input  ss_rdat, mem_rdat
  );

  modport slave (
    input  ss_act, ss_we, ss_addr, ss_wdat, mem_addr, mem_we, mem_wdat,
    output ss_rdat, mem_rdat
  );

endinterface

// File: rtl/ss_delay_cnt.sv
// Loadable down-counter that times the setup and strobe phases; zero marks the last wait cycle.
module ss_delay_cnt
  import ss_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ss_sequencer.sv
// Walks every mapper save-state register: save copies them into the buffer RAM,
// load writes them back (skipping the read-only mapper index).
module ss_sequencer
  import ss_pkg::*;
#(
  parameter int REG_CNT    = 256,
  parameter int SETUP      = 2,
  parameter int STROBE_LEN = 4,
  parameter int RO_ADDR    = RO_ADDR_DFLT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_save,
  input  logic           cmd_load,
  output logic           busy,
  output logic           done,
  output logic           err,
  ss_sequencer_if.master bus
);

  localparam logic [SS_AW-1:0] LAST_IDX = SS_AW'(REG_CNT - 1);
  localparam logic [SS_AW-1:0] RO_IDX   = SS_AW'(RO_ADDR);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] STB_LD   = CNT_W'(STROBE_LEN - 1);

  state_t           state, state_nxt;
  op_t              op, op_nxt;
  logic [SS_AW-1:0] idx, idx_nxt;
  logic [SS_DW-1:0] wdat_q;
  logic             err_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  ss_delay_cnt #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_SAVE;
      idx    <= '0;
      err    <= 1'b0;
      wdat_q <= '0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
      // Keep the captured buffer byte stable through strobe and hold.
      if (state == LD_SETUP) begin
        wdat_q <= bus.mem_rdat;
      end else if (state == FIN) begin
        wdat_q <= '0;
      end
    end
  end

  // NOTE: every signal gets a default before the case, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    idx_nxt   = idx;
    err_nxt   = err;
    cnt_load  = 1'b0;
    cnt_val   = SETUP_LD;

    case (state)
      IDLE: begin
        if (cmd_save && cmd_load) begin
          err_nxt = 1'b1;
        end else if (cmd_save) begin
          state_nxt = SV_SETUP;
          op_nxt    = OP_SAVE;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
          cnt_load  = 1'b1;
        end else if (cmd_load) begin
          state_nxt = LD_RD;
          op_nxt    = OP_LOAD;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      SV_SETUP: if (cnt_zero) state_nxt = SV_CAP;
      SV_CAP:   state_nxt = NEXT;
      LD_RD: begin
        if (idx == RO_IDX) begin
          state_nxt = NEXT;
        end else begin
          state_nxt = LD_SETUP;
          cnt_load  = 1'b1;
        end
      end
      LD_SETUP: begin
        if (cnt_zero) begin
          state_nxt = LD_STB;
          cnt_load  = 1'b1;
          cnt_val   = STB_LD;
        end
      end
      LD_STB:  if (cnt_zero) state_nxt = LD_HOLD;
      LD_HOLD: state_nxt = NEXT;
      NEXT: begin
        if (idx == LAST_IDX) begin
          state_nxt = FIN;
        end else begin
          idx_nxt = idx + 1'b1;
          if (op == OP_LOAD) begin
            state_nxt = LD_RD;
          end else begin
            state_nxt = SV_SETUP;
            cnt_load  = 1'b1;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && (cmd_save || cmd_load)) begin
      err_nxt = 1'b1;
    end
  end

  assign busy = (state != IDLE) && (state != FIN);
  assign done = (state == FIN);

  assign bus.ss_act   = busy;
  assign bus.ss_we    = (state == LD_STB);
  assign bus.ss_addr  = idx;
  // Buffer data is forwarded during setup so it is valid for every setup cycle.
  assign bus.ss_wdat  = (state == LD_SETUP) ? bus.mem_rdat : wdat_q;
  assign bus.mem_addr = idx;
  assign bus.mem_we   = (state == SV_CAP);
  assign bus.mem_wdat = (state == SV_CAP) ? bus.ss_rdat : '0;

endmodule

// File: tb/tb_ss_sequencer.sv
// Directed bench for ss_sequencer: default instance plus a REG_CNT=4 instance,
// with a buffer RAM model and a mapper model returning addr^8'h5A.
module tb_ss_sequencer;
  import ss_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_save = 1'b0, cmd_load = 1'b0, busy, done, err;
  logic cmd_save4 = 1'b0, cmd_load4 = 1'b0, busy4, done4, err4;
  int   n_vec = 0;
  int   n_miss = 0;
  int   fill_mode = 0;
  logic [7:0] ram  [256];
  logic [7:0] ram4 [256];

  always #5 clk = ~clk;

  ss_sequencer_if bus ();
  ss_sequencer_if bus4 ();

  ss_sequencer dut (
    .clk(clk), .rst(rst), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  ss_sequencer #(.REG_CNT(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_save(cmd_save4), .cmd_load(cmd_load4),
    .busy(busy4), .done(done4), .err(err4), .bus(bus4)
  );

  assign bus.ss_rdat  = bus.ss_addr ^ 8'h5A;
  assign bus4.ss_rdat = bus4.ss_addr ^ 8'h5A;

  // Buffer RAMs: 1-cycle read latency; fill_mode 1 = ~i, 2 = zero.
  always @(posedge clk) begin
    if (fill_mode != 0) begin
      for (int i = 0; i < 256; i++) begin
        ram[i]  <= (fill_mode == 1) ? ~8'(i) : 8'h00;
        ram4[i] <= 8'h00;
      end
    end else begin
      if (bus.mem_we)  ram[bus.mem_addr]   <= bus.mem_wdat;
      if (bus4.mem_we) ram4[bus4.mem_addr] <= bus4.mem_wdat;
    end
    bus.mem_rdat  <= ram[bus.mem_addr];
    bus4.mem_rdat <= ram4[bus4.mem_addr];
  end

  // Strobe monitor, sampled on the falling edge.
  logic       we_d = 1'b0;
  logic [7:0] addr_d = 8'h00, wdat_d = 8'h00;
  int we_len = 0, wdat_run = 0;
  int pulses = 0, bad_len = 0, ro_hits = 0, bad_data = 0, unstable = 0;
  int moved_in_we = 0, rise_moved = 0, mem_writes = 0;
  int max_addr4 = 0, mem_writes4 = 0, pulses4 = 0;

  always @(negedge clk) begin
    wdat_run = (bus.ss_wdat == wdat_d) ? wdat_run + 1 : 1;
    if (bus.ss_we && !we_d) begin
      pulses++;
      we_len = 1;
      if (bus.ss_addr == 8'd127) ro_hits++;
      if (bus.ss_wdat != ~bus.ss_addr) bad_data++;
      if (wdat_run < 3) unstable++;
      if (bus.ss_addr != addr_d) rise_moved++;
    end else if (bus.ss_we) begin
      we_len++;
      if (bus.ss_addr != addr_d || bus.ss_wdat != wdat_d) moved_in_we++;
    end else if (we_d && we_len != 4) begin
      bad_len++;
    end
    if (bus.mem_we) mem_writes++;
    if (bus4.ss_act || bus4.mem_we) begin
      if (int'(bus4.ss_addr) > max_addr4)  max_addr4 = int'(bus4.ss_addr);
      if (int'(bus4.mem_addr) > max_addr4) max_addr4 = int'(bus4.mem_addr);
    end
    if (bus4.mem_we) mem_writes4++;
    if (bus4.ss_we || (bus4.ss_wdat != 8'h00)) pulses4++;
    we_d   = bus.ss_we;
    addr_d = bus.ss_addr;
    wdat_d = bus.ss_wdat;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic l);
    cmd_save = s;
    cmd_load = l;
    tick();
    cmd_save = 1'b0;
    cmd_load = 1'b0;
  endtask

  task automatic fill(input int mode);
    fill_mode = mode;
    tick();
    fill_mode = 0;
  endtask

  // cyc is the cycle index after the accept cycle; budget bounds the wait.
  task automatic wait_done(input int start, input int budget, output int cyc);
    cyc = start;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  function automatic int save_errs();
    int e = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] != (8'(i) ^ 8'h5A)) e++;
    end
    return e;
  endfunction

  initial begin
    int cyc, dn;
    int p0, bl0, ro0, bd0, un0, mv0, rm0, mw0;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_flags", int'({busy, done, err, bus.ss_act, bus.ss_we, bus.mem_we}), 0);
    check("rst_ss_addr", bus.ss_addr, 0);
    check("rst_ss_wdat", bus.ss_wdat, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdat", bus.mem_wdat, 0);
    fill(2);
    rst = 1'b0;
    tick();

    // REG_CNT=4 save: 4*(2+2)+1 = 17 cycles, addresses 0..3 only.
    cmd_save4 = 1'b1;
    tick();
    cmd_save4 = 1'b0;
    check("rc4_busy", busy4, 1);
    cyc = 1;
    while (!done4 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("rc4_cycles", cyc, 17);
    for (int i = 0; i < 4; i++) check($sformatf("rc4_data%0d", i), ram4[i], i ^ 'h5A);
    check("rc4_untouched4", ram4[4], 0);
    check("rc4_max_addr", max_addr4, 3);
    check("rc4_mem_writes", mem_writes4, 4);
    check("rc4_no_we", pulses4, 0);
    check("rc4_err", err4, 0);
    tick();

    // Default save: 256*(2+2)+1 = 1025 cycles.
    p0  = pulses;
    mw0 = mem_writes;
    issue(1'b1, 1'b0);
    check("sv_busy", busy, 1);
    check("sv_act", bus.ss_act, 1);
    wait_done(1, 1200, cyc);
    check("sv_cycles", cyc, 1025);
    check("sv_busy_at_done", busy, 0);
    check("sv_act_at_done", bus.ss_act, 0);
    tick();
    check("sv_done_one_cycle", done, 0);
    check("sv_data_errs", save_errs(), 0);
    check("sv_data0", ram[0], 'h5A);
    check("sv_data127", ram[127], 'h25);
    check("sv_data255", ram[255], 'hA5);
    check("sv_no_we", pulses - p0, 0);
    check("sv_mem_writes", mem_writes - mw0, 256);
    check("sv_err", err, 0);

    // Load of ~i: 255*9 + 2 + 1 = 2298 cycles, 255 strobes.
    fill(1);
    p0 = pulses; bl0 = bad_len; ro0 = ro_hits; bd0 = bad_data;
    un0 = unstable; mv0 = moved_in_we; rm0 = rise_moved; mw0 = mem_writes;
    issue(1'b0, 1'b1);
    check("ld_first_addr", bus.ss_addr, 0);
    wait_done(1, 3000, cyc);
    check("ld_cycles", cyc, 2298);
    check("ld_pulses", pulses - p0, 255);
    check("ld_pulse_len", bad_len - bl0, 0);
    check("ld_ro_skipped", ro_hits - ro0, 0);
    check("ld_wdat_value", bad_data - bd0, 0);
    check("ld_wdat_setup", unstable - un0, 0);
    check("ld_stable_in_we", moved_in_we - mv0, 0);
    check("ld_addr_at_rise", rise_moved - rm0, 0);
    check("ld_no_mem_we", mem_writes - mw0, 0);
    tick();

    // Simultaneous commands are rejected; a later save clears err.
    issue(1'b1, 1'b1);
    check("both_busy", busy, 0);
    check("both_err", err, 1);
    check("both_act", bus.ss_act, 0);
    repeat (3) tick();
    check("both_still_idle", busy, 0);
    fill(2);
    issue(1'b1, 1'b0);
    check("both_err_cleared", err, 0);
    check("both_then_busy", busy, 1);
    wait_done(1, 1200, cyc);
    check("both_save_cycles", cyc, 1025);
    check("both_save_data", save_errs(), 0);
    tick();

    // cmd_load at idx 10 of a save is ignored but flagged.
    fill(2);
    issue(1'b1, 1'b0);
    cyc = 1;
    while (bus.ss_addr != 8'd10 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("mid_reach_idx10", bus.ss_addr, 10);
    cmd_load = 1'b1;
    tick();
    cyc++;
    cmd_load = 1'b0;
    check("mid_err", err, 1);
    check("mid_still_busy", busy, 1);
    wait_done(cyc, 1200, cyc);
    check("mid_save_cycles", cyc, 1025);
    check("mid_save_data", save_errs(), 0);
    check("mid_err_sticky", err, 1);
    tick();

    // rst during the strobe at idx 40, then a clean full load.
    fill(1);
    issue(1'b0, 1'b1);
    cyc = 1;
    while (!(bus.ss_we && bus.ss_addr == 8'd40) && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("rst_mid_at_stb40", int'({bus.ss_we, bus.ss_addr}), int'({1'b1, 8'd40}));
    rst = 1'b1;
    tick();
    check("rst_mid_we", bus.ss_we, 0);
    check("rst_mid_act", bus.ss_act, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      tick();
      if (done) dn++;
    end
    check("rst_mid_no_done", dn, 0);
    p0 = pulses; ro0 = ro_hits; bd0 = bad_data; bl0 = bad_len;
    issue(1'b0, 1'b1);
    check("reload_addr0", bus.ss_addr, 0);
    wait_done(1, 3000, cyc);
    check("reload_cycles", cyc, 2298);
    check("reload_pulses", pulses - p0, 255);
    check("reload_ro_skipped", ro_hits - ro0, 0);
    check("reload_wdat_value", bad_data - bd0, 0);
    check("reload_pulse_len", bad_len - bl0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ss_sequencer.md
Name: ss_sequencer

Overview:
- Initiator side of the mapper save-state port.
- Walks every mapper save-state register. On save, it reads each one through ss_addr/ss_rdat into a snapshot buffer RAM. On load, it writes each one back from that buffer using ss_act/ss_we plus a data bus.
- Sits between the system snapshot controller and the active mapper's ss_ctrl inputs.

Parameters:
- REG_CNT, 256, number of save-state addresses walked (0..REG_CNT-1); legal range 2..256.
- SETUP, 2, clk cycles that address and data are stable before the sample or strobe.
- STROBE_LEN, 4, clk cycles ss_we is held high. Must span at least one m2 falling edge, where the mapper latches.
- RO_ADDR, 127, read-only address (mapper index); saved normally, skipped on load.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_save  in  1  one-cycle pulse: start save.
- cmd_load  in  1  one-cycle pulse: start load.
- busy  out  1  high from the cycle after an accepted command until done.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky; set on an illegal command; cleared by the next accepted command or rst.
- ss_act  out  1  high for the whole operation.
- ss_we  out  1  mapper write strobe.
- ss_addr  out  8  mapper register address.
- ss_wdat  out  8  data the top muxes onto cpu_dat while ss_act.
- ss_rdat  in  8  mapper readback; combinational from ss_addr.
- mem_addr  out  8  buffer RAM address.
- mem_we  out  1  buffer RAM write enable.
- mem_wdat  out  8  buffer RAM write data.
- mem_rdat  in  8  buffer RAM read data; 1-cycle latency after mem_addr.

Behaviour:
- Reset values: busy, done, err, ss_act, ss_we, mem_we = 0; ss_addr, ss_wdat, mem_addr, mem_wdat = 0; state IDLE.
- Command acceptance (IDLE only):
  - cmd_save alone → SV_SETUP; cmd_load alone → LD_RD.
  - Both in the same cycle → stay IDLE, set err.
  - Any cmd while busy → ignored, sets err.
- Address counter idx is 8 bits. Termination is compared against REG_CNT-1; no wrap is used.
- Save path:
  - SV_SETUP: ss_act=1, ss_addr=idx; wait SETUP cycles.
  - SV_CAP: mem_addr=idx, mem_wdat=ss_rdat, mem_we=1 for exactly 1 cycle.
  - NEXT: if idx==REG_CNT-1 go to FIN, else idx+1 and go to SV_SETUP.
- Load path:
  - LD_RD: mem_addr=idx; wait 1 cycle.
  - LD_SETUP: latch ss_wdat=mem_rdat, ss_addr=idx; wait SETUP cycles.
  - LD_STB: ss_we=1 for STROBE_LEN cycles.
  - LD_HOLD: ss_we=0 with addr/data held 1 cycle.
  - NEXT.
  - If idx==RO_ADDR, LD_RD goes straight to NEXT; no strobe is issued.
- FIN: ss_act=0, busy=0, done=1 for one cycle, then IDLE.
- ss_addr/ss_wdat never change while ss_we=1.
- ss_we never rises in the same cycle ss_addr changes.
- Cycle counts:
  - Save: REG_CNT*(SETUP+2)+1 cycles from accept to done. For defaults: 1025.
  - Load: per non-skipped register, 1+SETUP+STROBE_LEN+1+1 = 9 cycles; skipped register, 2 cycles.
- rst mid-operation: all outputs return to reset values the next cycle. A partial buffer or mapper state is acceptable; no done pulse.
- REG_CNT < 256: addresses ≥ REG_CNT are never driven.

Decomposition:
- Shared package ss_pkg holds:
  - state enum (IDLE, SV_SETUP, SV_CAP, LD_RD, LD_SETUP, LD_STB, LD_HOLD, NEXT, FIN);
  - SS_AW=8, SS_DW=8;
  - default RO_ADDR=127.
- One sub-module, ss_delay_cnt: a loadable down-counter giving the SETUP and STROBE_LEN waits, with a zero flag.

Test Plan:
- Save with defaults; model mapper ss_rdat=addr^8'h5A → buffer[i]=i^8'h5A for all 256 addresses. done fires exactly 1025 cycles after cmd_save; ss_we never rises.
- Load with buffer[i]=~i:
  - exactly 255 ss_we pulses, each 4 cycles long;
  - no pulse at addr 127;
  - at each pulse, ss_wdat=~ss_addr and has been stable for ≥2 prior cycles.
- cmd_save and cmd_load in the same cycle → busy stays 0, err=1. A later cmd_save clears err and runs normally.
- cmd_load issued at idx 10 of an active save → ignored; save completes with all data correct; err=1.
- rst asserted during LD_STB at idx 40 → next cycle ss_we=0, ss_act=0, busy=0, no done. A fresh cmd_load then runs a full load from idx 0.
- REG_CNT=4 → save touches addresses 0..3 only; done after 17 cycles.
